// File: rtl/barreira_pkg.sv
// Shared types and defaults for the car-park barrier controller.
package barreira_pkg;

  typedef enum logic [2:0] {
    StClosed  = 3'd0,
    StOpening = 3'd1,
    StOpen    = 3'd2,
    StClosing = 3'd3,
    StFault   = 3'd4
  } state_e;

  localparam int unsigned BlinkDivDef = 25_000_000;
  localparam int unsigned HoldCycDef  = 250_000_000;
  localparam int unsigned MoveTmoDef  = 150_000_000;

  // Width of a counter that must hold values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic logic is_moving(input state_e s);
    return (s == StOpening) || (s == StClosing);
  endfunction

endpackage

// File: rtl/barreira_ctrl_blink.sv
// LED blink divider: phase goes to 1 on restart and toggles every BLINK_DIV enabled cycles.
module blink_tick_gen
  import barreira_pkg::*;
#(
  parameter int unsigned BLINK_DIV = BlinkDivDef
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  input  logic en_i,
  output logic phase_d_o
);

  localparam int unsigned CntW = cnt_width(BLINK_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart_i) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (en_i) begin
      if (cnt_q == CntW'(BLINK_DIV - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Next phase is exported so the owner can register it alongside its state.
  assign phase_d_o = phase_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/barreira_ctrl.sv
// Barrier sequencing FSM with hold/travel counters and registered outputs.
// Define BARREIRA_REVERSE_EN to reopen the barrier when SENSOR trips during closing.
module barreira_ctrl
  import barreira_pkg::*;
#(
  parameter int unsigned BLINK_DIV = BlinkDivDef,
  parameter int unsigned HOLD_CYC  = HoldCycDef,
  parameter int unsigned MOVE_TMO  = MoveTmoDef
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic REQ,
  input  logic SENSOR,
  input  logic LIM_UP,
  input  logic LIM_DN,
  input  logic CLR,
  output logic MOTOR_UP,
  output logic MOTOR_DN,
  output logic LED,
  output logic BARREIRA,
  output logic FAULT
);

  localparam int unsigned TrW   = cnt_width(MOVE_TMO);
  localparam int unsigned HoldW = cnt_width(HOLD_CYC);

  state_e           state_q, state_d;
  logic [TrW-1:0]   tr_q, tr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic motor_up_q, motor_up_d, motor_dn_q, motor_dn_d;
  logic led_q, led_d, open_q, open_d, fault_q, fault_d;
  logic blink_restart, blink_en, blink_phase_d;
  logic tmo, both_lim;

  assign tmo      = (tr_q == TrW'(MOVE_TMO - 1));
  assign both_lim = LIM_UP && LIM_DN;

  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    case (state_q)
      StClosed: if (REQ) state_d = StOpening;
      StOpening: begin
        if (both_lim)    state_d = StFault;
        else if (LIM_UP) state_d = StOpen;
        else if (tmo)    state_d = StFault;
      end
      StOpen: begin
        if (!SENSOR) begin
          if (hold_q == HoldW'(HOLD_CYC - 1)) state_d = StClosing;
          else                                hold_d  = hold_q + 1'b1;
        end
      end
      StClosing: begin
        if (both_lim)    state_d = StFault;
`ifdef BARREIRA_REVERSE_EN
        else if (SENSOR) state_d = StOpening;
`endif
        else if (LIM_DN) state_d = StClosed;
        else if (tmo)    state_d = StFault;
      end
      StFault: if (CLR) state_d = LIM_DN ? StClosed : StClosing;
      default: state_d = StClosed;
    endcase

    // Travel counter restarts on any state change and saturates instead of wrapping.
    if ((state_d != state_q) || !is_moving(state_q)) tr_d = '0;
    else if (tr_q != '1)                              tr_d = tr_q + 1'b1;
    else                                              tr_d = tr_q;

    blink_restart = is_moving(state_d) && (state_d != state_q);
    blink_en      = is_moving(state_q) && (state_d == state_q);

    motor_up_d = (state_d == StOpening);
    motor_dn_d = (state_d == StClosing);
    open_d     = (state_d == StOpen);
    fault_d    = (state_d == StFault);
    unique case (state_d)
      StOpening, StClosing: led_d = blink_phase_d;
      StOpen, StFault:      led_d = 1'b1;
      default:              led_d = 1'b0;
    endcase
  end

  blink_tick_gen #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clk      (CLK),
    .rst_n    (RST_N),
    .restart_i(blink_restart),
    .en_i     (blink_en),
    .phase_d_o(blink_phase_d)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StClosed;
      tr_q       <= '0;
      hold_q     <= '0;
      motor_up_q <= 1'b0;
      motor_dn_q <= 1'b0;
      led_q      <= 1'b0;
      open_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tr_q       <= tr_d;
      hold_q     <= hold_d;
      motor_up_q <= motor_up_d;
      motor_dn_q <= motor_dn_d;
      led_q      <= led_d;
      open_q     <= open_d;
      fault_q    <= fault_d;
    end
  end

  assign MOTOR_UP = motor_up_q;
  assign MOTOR_DN = motor_dn_q;
  assign LED      = led_q;
  assign BARREIRA = open_q;
  assign FAULT    = fault_q;

  motors_exclusive: assert property (@(posedge CLK) disable iff (!RST_N)
    !(MOTOR_UP && MOTOR_DN));

endmodule

// File: tb/tb_barreira_ctrl.sv
// Scoreboard bench for barreira_ctrl: a cycle-level behavioural model predicts outputs.
module tb_barreira_ctrl;

  localparam int BlinkDiv = 4;
  localparam int HoldCyc  = 10;
  localparam int MoveTmo  = 20;
`ifdef BARREIRA_REVERSE_EN
  localparam bit Reverse = 1'b1;
`else
  localparam bit Reverse = 1'b0;
`endif

  typedef enum int {Shut, Rising, Up, Falling, Broken} phase_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0, req = 1'b0, sensor = 1'b0, lim_up = 1'b0, lim_dn = 1'b1, clr = 1'b0;
  logic motor_up, motor_dn, led, barreira, fault;

  barreira_ctrl #(
    .BLINK_DIV(BlinkDiv),
    .HOLD_CYC (HoldCyc),
    .MOVE_TMO (MoveTmo)
  ) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .REQ     (req),
    .SENSOR  (sensor),
    .LIM_UP  (lim_up),
    .LIM_DN  (lim_dn),
    .CLR     (clr),
    .MOTOR_UP(motor_up),
    .MOTOR_DN(motor_dn),
    .LED     (led),
    .BARREIRA(barreira),
    .FAULT   (fault)
  );

  always #5 clk = ~clk;

  phase_t     m_st   = Shut;
  int         m_age  = 0;  // cycles since the current state was entered
  int         m_idle = 0;  // consecutive SENSOR-clear cycles while up
  logic [4:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  // {MOTOR_UP, MOTOR_DN, LED, BARREIRA, FAULT}
  function automatic logic [4:0] model_out();
    logic l;
    case (m_st)
      Shut:       l = 1'b0;
      Up, Broken: l = 1'b1;
      default:    l = ((m_age / BlinkDiv) % 2) == 0;
    endcase
    return {m_st == Rising, m_st == Falling, l, m_st == Up, m_st == Broken};
  endfunction

  task automatic model_update();
    phase_t nxt;
    if (!rst_n) begin
      m_st = Shut; m_age = 0; m_idle = 0;
      return;
    end
    nxt = m_st;
    case (m_st)
      Shut:    if (req) nxt = Rising;
      Rising: begin
        if (lim_up && lim_dn)         nxt = Broken;
        else if (lim_up)              nxt = Up;
        else if (m_age == MoveTmo - 1) nxt = Broken;
      end
      Up: begin
        if (sensor)                     m_idle = 0;
        else if (m_idle == HoldCyc - 1) nxt = Falling;
        else                            m_idle++;
      end
      Falling: begin
        if (lim_up && lim_dn)          nxt = Broken;
        else if (Reverse && sensor)    nxt = Rising;
        else if (lim_dn)               nxt = Shut;
        else if (m_age == MoveTmo - 1) nxt = Broken;
      end
      default: if (clr) nxt = lim_dn ? Shut : Falling;
    endcase
    if (nxt != m_st) begin
      m_age = 0; m_idle = 0;
    end else begin
      m_age++;
    end
    m_st = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  // Drives limits/CLR so that the model (and DUT) return to the closed state.
  task automatic settle();
    for (int i = 0; i < 80 && m_st != Shut; i++) begin
      req = 1'b0; sensor = 1'b0;
      clr    = (m_st == Broken);
      lim_up = (m_st == Rising);
      lim_dn = (m_st == Falling) || (m_st == Broken);
      step();
    end
    clr = 1'b0; lim_up = 1'b0; lim_dn = 1'b1;
  endtask

  task automatic start_open();
    req = 1'b1; step();
    req = 1'b0; lim_dn = 1'b0;
  endtask

  initial begin : monitor
    logic [4:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {motor_up, motor_dn, led, barreira, fault};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got=%b want=%b (up dn led open fault)", $time, a, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Normal cycle: 6 cycles of travel, open hold, close on LIM_DN.
    start_open();
    repeat (5) step();
    lim_up = 1'b1; step();
    for (int i = 0; i < 12 && m_st != Falling; i++) step();
    lim_up = 1'b0;
    repeat (7) step();
    lim_dn = 1'b1; step();
    step();

    // Hold extended by occupied sensor.
    start_open();
    repeat (3) step();
    lim_up = 1'b1; step();
    sensor = 1'b1; repeat (15) step();
    sensor = 1'b0;
    for (int i = 0; i < 12 && m_st != Falling; i++) step();
    lim_up = 1'b0;

    // Sensor trips during closing.
    repeat (3) step();
    sensor = 1'b1; repeat (2) step();
    sensor = 1'b0; repeat (3) step();
    settle();

    // Opening timeout, CLR with barrier not down, closing timeout, CLR with barrier down.
    start_open();
    repeat (24) step();
    clr = 1'b1; step();
    clr = 1'b0; repeat (22) step();
    clr = 1'b1; lim_dn = 1'b1; step();
    clr = 1'b0; step();

    // Limit wins over timeout on the last allowed cycle.
    start_open();
    repeat (19) step();
    lim_up = 1'b1; step();
    settle();

    // Both limits at once while opening.
    start_open();
    repeat (2) step();
    lim_up = 1'b1; lim_dn = 1'b1; step();
    lim_up = 1'b0; step();
    settle();

    // Asynchronous reset mid-opening.
    start_open();
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({motor_up, motor_dn, led, barreira, fault} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset got=%b want=00000", {motor_up, motor_dn, led, barreira, fault});
    end
    repeat (2) step();
    lim_dn = 1'b1; rst_n = 1'b1;
    step();

    // Randomised traffic.
    repeat (500) begin
      req    = ($urandom_range(0, 3) == 0);
      sensor = ($urandom_range(0, 3) == 0);
      lim_up = ($urandom_range(0, 7) == 0);
      lim_dn = ($urandom_range(0, 7) == 0);
      clr    = ($urandom_range(0, 15) == 0);
      step();
    end
    settle();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
